// File: rtl/test_encrypt.sv
// Iterative PRESENT-80 encryptor: one round per clock, free-running LOAD -> 31 ROUNDs -> DONE.
// Each result is registered into ciphertext and flagged by a one-cycle done pulse.
module test_encrypt #(
  parameter int KEY_SIZE   = 80,
  parameter int BLOCK_SIZE = 64,
  parameter int NUM_ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_SIZE-1:0]   orig_key,
  input  logic [BLOCK_SIZE-1:0] plaintext,
  output logic [BLOCK_SIZE-1:0] ciphertext,
  output logic                  done
);

  typedef enum logic [1:0] {LOAD, ROUND, DONE} fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [BLOCK_SIZE-1:0] blk_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [4:0]            rc_q;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 is the fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  // Rotate left by 61, substitute the top nibble, fold the round counter into bits 19:15.
  function automatic logic [79:0] key_next(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox4(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= LOAD;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      LOAD:    fsm_d = ROUND;
      ROUND:   if (rc_q == 5'(NUM_ROUNDS - 1)) fsm_d = DONE;
      DONE:    fsm_d = LOAD;
      default: fsm_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q      <= '0;
      key_q      <= '0;
      rc_q       <= 5'd1;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        LOAD: begin
          blk_q <= plaintext;
          key_q <= orig_key;
          rc_q  <= 5'd1;
        end
        ROUND: begin
          blk_q <= p_layer(sbox_layer(blk_q ^ key_q[79:16]));
          key_q <= key_next(key_q, rc_q);
          rc_q  <= rc_q + 5'd1;
        end
        DONE: begin
          ciphertext <= blk_q ^ key_q[79:16];
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_encrypt.sv
// Directed bench for test_encrypt: known PRESENT-80 vectors, back-to-back timing, mid-run reset.
module tb_test_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] orig_key;
  logic [63:0] plaintext;
  logic [63:0] ciphertext;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] pts  [4] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [79:0] keys [4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
  logic [63:0] exps [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                            64'hA112FFC72F68417B, 64'h3333DCD3213210D2};

  test_encrypt dut (
    .clk        (clk),
    .rst        (rst),
    .orig_key   (orig_key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Counts rising edges until done is seen (0 on timeout); snapshots ciphertext at edge 10.
  task automatic wait_done(output int cycles, output logic [63:0] mid_ct);
    cycles = 0;
    mid_ct = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) mid_ct = ciphertext;
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    int          idx;
    logic [63:0] mid;
    logic [63:0] prev;

    rst       = 1'b1;
    plaintext = pts[0];
    orig_key  = keys[0];
    repeat (2) @(posedge clk);
    #1;
    check("reset_ct", ciphertext, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    wait_done(cyc, mid);
    check("first_latency", 64'(cyc), 64'd33);
    check("vec0_ct", ciphertext, exps[0]);
    prev = exps[0];

    for (int v = 1; v <= 4; v++) begin
      idx       = v % 4;
      plaintext = pts[idx];
      orig_key  = keys[idx];
      wait_done(cyc, mid);
      check($sformatf("period_v%0d", v), 64'(cyc), 64'd33);
      check($sformatf("hold_v%0d", v), mid, prev);
      check($sformatf("ct_v%0d", v), ciphertext, exps[idx]);
      prev = exps[idx];
    end

    plaintext = pts[1];
    orig_key  = keys[1];
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_done", {63'h0, done}, 64'h0);
    check("midrst_ct", ciphertext, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(cyc, mid);
    check("post_rst_latency", 64'(cyc), 64'd33);
    check("post_rst_ct", ciphertext, exps[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
